// File: rtl/simple_fifo.sv
// simple_fifo
//   Synchronous first-word-fall-through FIFO between the UART receive stage
//   and the consumer logic. The oldest stored word is always presented on
//   dout while the FIFO is not empty. A read pops that word.
//
//   Handshake semantics:
//     - A write is accepted when we=1 and full=0 at the rising edge.
//     - A read is accepted when re=1 and empty=0 at the rising edge.
//     - Both decisions use the registered full/empty at the start of the
//       cycle. A pop does not free space for a same-cycle write when full.
//       A push does not make data readable in the same cycle when empty.
//     - A rejected write sets the sticky overflow flag. A rejected read sets
//       the sticky underflow flag. Rejected operations change nothing else.
//
//   Ports:
//     clk          clock, rising edge
//     rst          synchronous active-high reset (stored words are discarded)
//     din          write data
//     we           write request
//     full         count == DEPTH
//     dout         oldest stored word (meaningful only while empty == 0)
//     re           read / pop request
//     empty        count == 0
//     count        number of stored words, 0..DEPTH
//     overflow     sticky, set by a write attempted while full
//     underflow    sticky, set by a read attempted while empty
//     clear_flags  clears overflow/underflow (a same-cycle new error wins)

module simple_fifo #(
    parameter int WORD_WIDTH = 32'd8,
    parameter int DEPTH_LOG2 = 32'd4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  we,
    output logic                  full,
    output logic [WORD_WIDTH-1:0] dout,
    input  logic                  re,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_flags
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // count value meaning "completely full": only the MSB set
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status is derived from the registered count only
    assign full   = (count_q == FULL_COUNT);
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    assign wr_acc = we & ~full;
    assign rd_acc = re & ~empty;

    // First-word-fall-through: combinational read at the registered pointer
    assign dout = mem[rd_ptr];

    // Storage has no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH because they are DEPTH_LOG2 bits wide
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as clear_flags wins
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (clear_flags) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
            if (we & full) begin
                overflow_q <= 1'b1;
            end
            if (re & empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simple_fifo.sv
// tb_simple_fifo
//   Self-checking bench for simple_fifo (WORD_WIDTH=8, DEPTH_LOG2=4).
//   Inputs change 1 time unit after each rising edge and outputs are sampled
//   at the same point, away from the active edge. Written words are pushed
//   into exp_q when the bench's own model says the write is accepted, and
//   popped/compared against dout when the model says a read is accepted.

module tb_simple_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         we;
    logic         full;
    logic [W-1:0] dout;
    logic         re;
    logic         empty;
    logic [4:0]   count;
    logic         overflow;
    logic         underflow;
    logic         clear_flags;

    int checks = 0;
    int errors = 0;

    // bench-side reference model
    logic [W-1:0] exp_q[$];
    int           mdl_count = 0;
    logic         mdl_ovf   = 1'b0;
    logic         mdl_udf   = 1'b0;

    simple_fifo #(.WORD_WIDTH(W), .DEPTH_LOG2(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .we          (we),
        .full        (full),
        .dout        (dout),
        .re          (re),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clear_flags (clear_flags)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // One clock cycle with the given inputs. Updates the model and pops and
    // compares the scoreboard on an accepted read.
    task automatic cycle(input logic w, input logic [W-1:0] d, input logic r, input logic cf);
        logic         wacc;
        logic         racc;
        logic [W-1:0] exp;
        we = w; din = d; re = r; clear_flags = cf;
        wacc = w && (mdl_count != DEPTH);
        racc = r && (mdl_count != 0);
        if (racc) begin
            exp = exp_q.pop_front();
            checks++;
            if (dout !== exp) begin
                errors++;
                $display("FAIL pop_data: dout=%h expected=%h", dout, exp);
            end
        end
        if (wacc) exp_q.push_back(d);
        if (cf) begin mdl_ovf = 1'b0; mdl_udf = 1'b0; end
        if (w && mdl_count == DEPTH) mdl_ovf = 1'b1;
        if (r && mdl_count == 0) mdl_udf = 1'b1;
        if (wacc && !racc) mdl_count++;
        if (racc && !wacc) mdl_count--;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0; clear_flags = 1'b0; din = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        mdl_count = 0; mdl_ovf = 1'b0; mdl_udf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags: ovf=%b udf=%b want 0 0", overflow, underflow);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, words[i], 1'b0, 1'b0);
            checks++;
            if (count !== 5'(i + 1)) begin errors++; $display("FAIL basic_count: got %0d want %0d", count, i + 1); end
            checks++;
            if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b want 0", empty); end
        end
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL basic_head: got %h want 11", dout); end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL basic_drained: empty=%b count=%0d want 1 0", empty, count);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL fill_full: full=%b count=%0d want 1 16", full, count);
        end
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b want 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count_hold: got %0d want 16", count); end
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL fill_drained: empty=%b full=%b want 1 0", empty, full);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, W'(8'h85 + i), 1'b1, 1'b0);
            if (count !== 5'd5) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stream_count: %0d cycles with count!=5", bad); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL stream_flags: ovf=%b udf=%b want 0 0", overflow, underflow);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_drained: empty=%b want 1", empty); end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_underflow: got %b want 1", underflow); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL empty_rw_count: got %0d want 1", count); end
        checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL empty_rw_dout: got %h want 5a", dout); end
        cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_rw_overflow: got %b want 1", overflow); end
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL full_rw_count: got %0d want 15", count); end
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flags();
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow: got %b want 0", overflow); end
        cycle(1'b0, '0, 1'b1, 1'b1);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL set_wins_underflow: got %b want 1", underflow); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
        checks++; if (count !== 5'd7) begin errors++; $display("FAIL mid_pre_count: got %0d want 7", count); end
        do_reset();
        checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL mid_reset_status: count=%0d empty=%b full=%b want 0 1 0", count, empty, full);
        end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flags: ovf=%b udf=%b want 0 0", overflow, underflow);
        end
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        checks++; if (dout !== 8'hC3) begin errors++; $display("FAIL mid_after_dout: got %h want c3", dout); end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int bad = 0;
        logic w, r, cf;
        for (int i = 0; i < 300; i++) begin
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45);
            cf = ($urandom_range(0, 99) < 5);
            cycle(w, W'($urandom_range(0, 255)), r, cf);
            if (count !== 5'(mdl_count) || full !== (mdl_count == DEPTH) ||
                empty !== (mdl_count == 0) || overflow !== mdl_ovf || underflow !== mdl_udf) begin
                bad++;
                if (bad < 5)
                    $display("FAIL random_status: cyc %0d count=%0d/%0d ovf=%b/%b udf=%b/%b",
                             i, count, mdl_count, overflow, mdl_ovf, underflow, mdl_udf);
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL random_total: %0d bad cycles", bad); end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; din = '0; clear_flags = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_simultaneous();
        test_flags();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simple_fifo.md
# simple_fifo

Synchronous first-word-fall-through FIFO that buffers words between the UART receive stage and the consumer logic. The write port matches the receiver's `dout`/`we`/`full` handshake. The read port presents the oldest word continuously while not empty. Occupancy count and sticky overflow/underflow flags are provided for debug and flow control.

## Interface
- `WORD_WIDTH`, default 32'd8: width of each stored word.
- `DEPTH_LOG2`, default 32'd4: log2 of capacity, so DEPTH = 2**DEPTH_LOG2 (default 16). Legal range is 1..16.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  WORD_WIDTH  write data, sampled when a write is accepted.
- `we`  in  1  write request (single-cycle or sustained).
- `full`  out  1  high when count == DEPTH.
- `dout`  out  WORD_WIDTH  oldest stored word; valid only while `empty`==0.
- `re`  in  1  read/pop request.
- `empty`  out  1  high when count == 0.
- `count`  out  DEPTH_LOG2+1  current number of stored words, 0..DEPTH.
- `overflow`  out  1  sticky; set by a rejected write.
- `underflow`  out  1  sticky; set by a rejected read.
- `clear_flags`  in  1  clears `overflow` and `underflow`.

## Operation
- Storage is a DEPTH-entry memory array.
- Pointers:
  - `wr_ptr` and `rd_ptr` are each DEPTH_LOG2 bits wide and wrap modulo DEPTH.
  - `count` is DEPTH_LOG2+1 bits, so full and empty are unambiguous.
- A write is accepted when `wr_acc = we & ~full`. On acceptance:
  - mem[wr_ptr] <= din
  - wr_ptr <= wr_ptr+1
- A read is accepted when `rd_acc = re & ~empty`. On acceptance:
  - rd_ptr <= rd_ptr+1
- Acceptance is decided on the registered `full`/`empty` at the start of the cycle.
- A read in the same cycle does NOT free space for a write when full.
- A write in the same cycle does NOT make data readable when empty.
- Count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
- `full` = (count == DEPTH) and `empty` = (count == 0). Both are derived from the registered `count`.
- `dout` = mem[rd_ptr], combinational read of the registered pointer (FWFT).
  - When `empty`=1, `dout` is don't-care. The bench must not check it.
- Flags:
  - `overflow` <= 1 when `we & full`.
  - `underflow` <= 1 when `re & empty`.
  - `clear_flags` clears both flags. When `clear_flags` and a new error occur in the same cycle, set wins.
- Rejected operations do not alter pointers, count, or memory contents.
- Reset:
  - rst=1 forces wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset asserted mid-stream discards all stored words. After reset, empty=1 and full=0.

## Timing
- Reset values: full=0, empty=1, count=0, overflow=0, underflow=0, dout=X (don't-care).
- Write-to-read latency is 1 cycle. After the edge where a write into an empty FIFO is accepted:
  - `empty` drops.
  - `dout` shows that word in the same cycle `empty` drops.
- Read latency is 0: `dout` is valid before `re` is asserted. After the pop edge, `dout` shows the next word, or `empty` rises.
- After the accepting edge that makes count == DEPTH, `full` is high from the next cycle on.
- Sustained we=1 with re=1 and 0<count<DEPTH gives one write and one read per cycle, with count constant.
- Pointer wrap from DEPTH-1 to 0 must be seamless, with no bubble or duplicate.
- Receiver compatibility: the receiver samples `full` one cycle before pulsing `we`. A word may therefore arrive on the cycle `full` rises. That word is rejected and sets `overflow`; this is the defined drop behaviour.

## Test plan
- Reset, then write 0x11,0x22,0x33 on consecutive cycles.
  - Expect count 1,2,3 and empty=0 from the cycle after the first write.
  - Expect dout=0x11; pop three times and get 0x11,0x22,0x33, then empty=1 and count=0.
- Fill DEPTH=16 words 0x00..0x0F.
  - Expect full=1 and count=16.
  - A 17th write of 0xAA is rejected: overflow=1, count stays 16.
  - Draining yields exactly 0x00..0x0F.
- With count=5, hold we=1 and re=1 for 40 cycles using an incrementing pattern.
  - Expect count stays 5 and the read sequence is in order across several pointer wraps.
- Simultaneous-event corner cases:
  - Empty with we=1,re=1 writes 0x5A: underflow=1, count=1, dout=0x5A next cycle.
  - Full with we=1,re=1: the read is accepted, the write is rejected, overflow=1, count=15.
- Flag handling: with overflow=1, assert clear_flags and see overflow=0.
  - Assert clear_flags together with re on empty: underflow=1 (set wins).
- Reset mid-stream: with count=7, assert rst for 1 cycle.
  - Expect count=0, empty=1, full=0, flags 0.
  - A subsequent write of 0xC3 then read returns 0xC3.
